mc_control_fsm: RTL and testbench
=================================

# mc_control_fsm

Multicycle control sequencer for the MIPS32 datapath. It replaces single-cycle opcode decoding with a Moore state machine that steps each instruction through fetch, decode, execute, memory and writeback. It stalls on a shared instruction/data memory through a ready handshake. It drives every datapath mux, write-enable and ALU-operation select, and flags unsupported opcodes.

## Interface
- No parameters.
- `clk`  in  1  single system clock, rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `opcode`  in  6  IR[31:26]; sampled only in DECODE.
- `mem_ready`  in  1  memory done; sampled only in FETCH, MEM_READ and MEM_WRITE.
- `pc_write`, `pc_write_cond`, `ir_write`, `reg_write`  out  1 each  enables.
- `mem_read`, `mem_write`  out  1 each  memory requests.
- `i_or_d`  out  1  memory address select: 0 = PC, 1 = ALUOut.
- `mem_to_reg`  out  1  register write data: 0 = ALUOut, 1 = MDR.
- `reg_dst`  out  1  destination register: 0 = rt, 1 = rd.
- `alu_src_a`  out  1  ALU A input: 0 = PC, 1 = rs.
- `alu_src_b`  out  2  ALU B input: 00 = rt, 01 = constant 4, 10 = sign-extended immediate, 11 = sign-extended immediate << 2.
- `alu_op`  out  3  ALU operation: 000 add, 001 sub, 010 funct (R-type), 011 or, 100 slt, 101 and.
- `pc_source`  out  2  next-PC select: 00 = ALU result, 01 = ALUOut, 10 = jump target.
- `retire`  out  1  one-cycle pulse in the final cycle of each instruction.
- `illegal_op`  out  1  held high while in HALT.

## Operation
- States (4-bit encoding): RESET=0, FETCH=1, DECODE=2, MEM_ADDR=3, MEM_READ=4, MEM_WB=5, MEM_WRITE=6, R_EXEC=7, R_WB=8, I_EXEC=9, I_WB=10, BRANCH=11, JUMP=12, HALT=13.
- Outputs are Moore: decoded from the state plus the opcode register `op_q`. Every output not listed for a state is 0.
- RESET: all outputs 0. Next state is FETCH, unconditionally.
- FETCH: `mem_read`=1, `alu_src_b`=01, `alu_op`=000.
  - When `mem_ready`=1: `ir_write`=1 and `pc_write`=1 in that cycle, then go to DECODE.
  - Otherwise stay in FETCH with `ir_write`=0 and `pc_write`=0.
- DECODE: load `op_q`←`opcode`; `alu_src_b`=11, `alu_op`=000 (branch target into ALUOut). Next state by opcode:
  - 000000 → R_EXEC
  - 100011 (LW) and 101011 (SW) → MEM_ADDR
  - 001000 (ADDI), 001100 (ANDI), 001101 (ORI), 001010 (SLTI) → I_EXEC
  - 000100 (BEQ) → BRANCH
  - 000010 (J) → JUMP
  - any other opcode → HALT
- MEM_ADDR: `alu_src_a`=1, `alu_src_b`=10, `alu_op`=000. Next MEM_READ if `op_q` is LW, MEM_WRITE if SW.
- MEM_READ: `i_or_d`=1, `mem_read`=1. Hold until `mem_ready`, then go to MEM_WB.
- MEM_WB: `mem_to_reg`=1, `reg_write`=1, `retire`=1. Next FETCH.
- MEM_WRITE: `i_or_d`=1, `mem_write`=1. Hold until `mem_ready`; `retire`=1 in the ready cycle, then go to FETCH.
- R_EXEC: `alu_src_a`=1, `alu_src_b`=00, `alu_op`=010. Next R_WB.
- R_WB: `reg_dst`=1, `reg_write`=1, `retire`=1. Next FETCH.
- I_EXEC: `alu_src_a`=1, `alu_src_b`=10. `alu_op` by `op_q`: ADDI 000, ANDI 101, ORI 011, SLTI 100. Next I_WB.
- I_WB: `reg_write`=1, `retire`=1. Next FETCH.
- BRANCH: `alu_src_a`=1, `alu_src_b`=00, `alu_op`=001, `pc_write_cond`=1, `pc_source`=01, `retire`=1. Next FETCH.
- JUMP: `pc_write`=1, `pc_source`=10, `retire`=1. Next FETCH.
- HALT: all enables 0, `illegal_op`=1. Exit only through reset.

## Timing
- Reset is asynchronous: `rst_n` low forces state to RESET and `op_q` to 0 immediately. All outputs read 0 while reset is held and in the first cycle after release.
- Minimum cycles per instruction, counted from FETCH with zero memory wait: BEQ 3, J 3, R-type 4, I-type 4, SW 4, LW 5.
- Each cycle `mem_ready`=0 in FETCH, MEM_READ or MEM_WRITE adds exactly one cycle. The request stays asserted and the memory address select stays stable throughout the wait.
- `mem_ready` in any other state is ignored.
- `mem_ready` may be high in the first cycle of a request; it then completes with zero wait.
- `opcode` changes after DECODE have no effect until the next DECODE.
- Reset asserted during MEM_WRITE: `mem_write` drops asynchronously and no `retire` is issued.
- `retire` is never asserted in RESET, FETCH, DECODE or HALT.

## Structure
- Package `mc_ctrl_pkg` holds:
  - state encoding
  - opcode constants
  - `alu_op` codes
  - `alu_src_b` and `pc_source` encodings
- One sub-module: `mc_alu_op_decode`, the combinational `op_q`→`alu_op` mapping used in I_EXEC.
- State and `op_q` registers live in `mc_control_fsm`.

## Test plan
- Reset release, `opcode`=000000, `mem_ready` held 1 → sequence RESET, FETCH, DECODE, R_EXEC, R_WB. `reg_dst`=1 and `reg_write`=1 in R_WB. `retire` high in cycle 5 only.
- LW with `mem_ready`=0 for 3 cycles in MEM_READ → MEM_READ lasts 4 cycles with `mem_read`=1 and `i_or_d`=1. MEM_WB follows with `mem_to_reg`=1. Total 8 cycles from FETCH.
- ORI, ANDI, SLTI, ADDI each → `alu_op` 011, 101, 100, 000 respectively in I_EXEC. `alu_src_b`=10. `reg_dst`=0 in I_WB.
- BEQ then J back to back → BRANCH asserts `pc_write_cond`=1 with `pc_source`=01. JUMP asserts `pc_write`=1 with `pc_source`=10. Each instruction takes 3 cycles.
- `opcode`=111111 in DECODE → HALT with `illegal_op`=1. State stays in HALT for 20 cycles of toggling `mem_ready`. Reset returns it to RESET.
- SW: `rst_n` pulled low mid-MEM_WRITE → `mem_write` goes 0 without a clock edge. No `retire`. FETCH is reached 2 cycles after release.

Source files
------------

// File: rtl/mc_ctrl_pkg.sv
// Shared encodings for the multicycle MIPS32 control sequencer: state
// numbering, opcode values, ALU operation codes and datapath mux selects.
package mc_ctrl_pkg;

    typedef enum logic [3:0] {
        ST_RESET     = 4'd0,
        ST_FETCH     = 4'd1,
        ST_DECODE    = 4'd2,
        ST_MEM_ADDR  = 4'd3,
        ST_MEM_READ  = 4'd4,
        ST_MEM_WB    = 4'd5,
        ST_MEM_WRITE = 4'd6,
        ST_R_EXEC    = 4'd7,
        ST_R_WB      = 4'd8,
        ST_I_EXEC    = 4'd9,
        ST_I_WB      = 4'd10,
        ST_BRANCH    = 4'd11,
        ST_JUMP      = 4'd12,
        ST_HALT      = 4'd13
    } state_e;

    // Opcode field IR[31:26]
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;

    // ALU operation select
    localparam logic [2:0] ALU_ADD   = 3'b000;
    localparam logic [2:0] ALU_SUB   = 3'b001;
    localparam logic [2:0] ALU_FUNCT = 3'b010;
    localparam logic [2:0] ALU_OR    = 3'b011;
    localparam logic [2:0] ALU_SLT   = 3'b100;
    localparam logic [2:0] ALU_AND   = 3'b101;

    // ALU B-input select
    localparam logic [1:0] SRC_B_RT      = 2'b00;
    localparam logic [1:0] SRC_B_FOUR    = 2'b01;
    localparam logic [1:0] SRC_B_IMM     = 2'b10;
    localparam logic [1:0] SRC_B_IMM_SH2 = 2'b11;

    // Next-PC select
    localparam logic [1:0] PC_SRC_ALU    = 2'b00;
    localparam logic [1:0] PC_SRC_ALUOUT = 2'b01;
    localparam logic [1:0] PC_SRC_JUMP   = 2'b10;

    // Dispatch target chosen in DECODE; unsupported opcodes park in HALT.
    function automatic state_e decode_next(input logic [5:0] op);
        state_e nxt;
        case (op)
            OP_RTYPE:                       nxt = ST_R_EXEC;
            OP_LW, OP_SW:                   nxt = ST_MEM_ADDR;
            OP_ADDI, OP_ANDI, OP_ORI,
            OP_SLTI:                        nxt = ST_I_EXEC;
            OP_BEQ:                         nxt = ST_BRANCH;
            OP_J:                           nxt = ST_JUMP;
            default:                        nxt = ST_HALT;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/mc_alu_op_decode.sv
// Maps the latched opcode of an immediate-format instruction onto the ALU
// operation it needs during I_EXEC.
module mc_alu_op_decode
    import mc_ctrl_pkg::*;
(
    input  logic [5:0] op_q,
    output logic [2:0] alu_op
);

    // Immediate-op to ALU-op table; anything unexpected falls back to add
    always_comb begin
        alu_op = ALU_ADD;
        case (op_q)
            OP_ADDI: alu_op = ALU_ADD;
            OP_ANDI: alu_op = ALU_AND;
            OP_ORI:  alu_op = ALU_OR;
            OP_SLTI: alu_op = ALU_SLT;
            default: alu_op = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/mc_control_fsm.sv
// Multicycle control sequencer: a Moore FSM stepping each instruction through
// fetch/decode/execute/memory/writeback, stalling on the shared memory's
// ready handshake and driving every datapath select and enable.
module mc_control_fsm
    import mc_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] opcode,
    input  logic       mem_ready,
    output logic       pc_write,
    output logic       pc_write_cond,
    output logic       ir_write,
    output logic       reg_write,
    output logic       mem_read,
    output logic       mem_write,
    output logic       i_or_d,
    output logic       mem_to_reg,
    output logic       reg_dst,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [2:0] alu_op,
    output logic [1:0] pc_source,
    output logic       retire,
    output logic       illegal_op
);

    state_e     state_q, state_d;
    logic [5:0] op_q, op_d;
    logic [2:0] imm_alu_op;

    mc_alu_op_decode u_alu_op_decode (
        .op_q   (op_q),
        .alu_op (imm_alu_op)
    );

    // State and latched opcode; asynchronous reset so requests drop at once
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_RESET;
            op_q    <= 6'd0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
        end
    end

    // Next-state: opcode is only captured in DECODE, mem_ready only in the
    // three memory-access states
    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        case (state_q)
            ST_RESET:     state_d = ST_FETCH;
            ST_FETCH:     state_d = mem_ready ? ST_DECODE : ST_FETCH;
            ST_DECODE: begin
                op_d    = opcode;
                state_d = decode_next(opcode);
            end
            ST_MEM_ADDR: begin
                if (op_q == OP_LW)      state_d = ST_MEM_READ;
                else if (op_q == OP_SW) state_d = ST_MEM_WRITE;
                else                    state_d = ST_HALT;
            end
            ST_MEM_READ:  state_d = mem_ready ? ST_MEM_WB : ST_MEM_READ;
            ST_MEM_WB:    state_d = ST_FETCH;
            ST_MEM_WRITE: state_d = mem_ready ? ST_FETCH : ST_MEM_WRITE;
            ST_R_EXEC:    state_d = ST_R_WB;
            ST_R_WB:      state_d = ST_FETCH;
            ST_I_EXEC:    state_d = ST_I_WB;
            ST_I_WB:      state_d = ST_FETCH;
            ST_BRANCH:    state_d = ST_FETCH;
            ST_JUMP:      state_d = ST_FETCH;
            ST_HALT:      state_d = ST_HALT;
            // Unused encodings recover through RESET
            default:      state_d = ST_RESET;
        endcase
    end

    // Output decode from state (plus op_q / mem_ready where a state needs it)
    always_comb begin
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        ir_write      = 1'b0;
        reg_write     = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        i_or_d        = 1'b0;
        mem_to_reg    = 1'b0;
        reg_dst       = 1'b0;
        alu_src_a     = 1'b0;
        alu_src_b     = SRC_B_RT;
        alu_op        = ALU_ADD;
        pc_source     = PC_SRC_ALU;
        retire        = 1'b0;
        illegal_op    = 1'b0;
        case (state_q)
            ST_FETCH: begin
                // PC+4 computed every wait cycle, committed only when IR loads
                mem_read  = 1'b1;
                alu_src_b = SRC_B_FOUR;
                alu_op    = ALU_ADD;
                ir_write  = mem_ready;
                pc_write  = mem_ready;
            end
            ST_DECODE: begin
                // Speculative branch target into ALUOut
                alu_src_b = SRC_B_IMM_SH2;
                alu_op    = ALU_ADD;
            end
            ST_MEM_ADDR: begin
                alu_src_a = 1'b1;
                alu_src_b = SRC_B_IMM;
                alu_op    = ALU_ADD;
            end
            ST_MEM_READ: begin
                i_or_d   = 1'b1;
                mem_read = 1'b1;
            end
            ST_MEM_WB: begin
                mem_to_reg = 1'b1;
                reg_write  = 1'b1;
                retire     = 1'b1;
            end
            ST_MEM_WRITE: begin
                i_or_d    = 1'b1;
                mem_write = 1'b1;
                retire    = mem_ready;
            end
            ST_R_EXEC: begin
                alu_src_a = 1'b1;
                alu_src_b = SRC_B_RT;
                alu_op    = ALU_FUNCT;
            end
            ST_R_WB: begin
                reg_dst   = 1'b1;
                reg_write = 1'b1;
                retire    = 1'b1;
            end
            ST_I_EXEC: begin
                alu_src_a = 1'b1;
                alu_src_b = SRC_B_IMM;
                alu_op    = imm_alu_op;
            end
            ST_I_WB: begin
                reg_write = 1'b1;
                retire    = 1'b1;
            end
            ST_BRANCH: begin
                alu_src_a     = 1'b1;
                alu_src_b     = SRC_B_RT;
                alu_op        = ALU_SUB;
                pc_write_cond = 1'b1;
                pc_source     = PC_SRC_ALUOUT;
                retire        = 1'b1;
            end
            ST_JUMP: begin
                pc_write  = 1'b1;
                pc_source = PC_SRC_JUMP;
                retire    = 1'b1;
            end
            ST_HALT: begin
                illegal_op = 1'b1;
            end
            default: begin
            end
        endcase
    end

endmodule

// File: tb/tb_mc_control_fsm.sv
// Directed bench for mc_control_fsm: walks each instruction class cycle by
// cycle and compares the full control word against hand-built expectations.
module tb_mc_control_fsm;

    typedef logic [18:0] ctl_t;

    logic       clk;
    logic       rst_n;
    logic [5:0] opcode;
    logic       mem_ready;
    logic       pc_write, pc_write_cond, ir_write, reg_write;
    logic       mem_read, mem_write, i_or_d, mem_to_reg, reg_dst, alu_src_a;
    logic [1:0] alu_src_b;
    logic [2:0] alu_op;
    logic [1:0] pc_source;
    logic       retire, illegal_op;

    int n_tests = 0;
    int n_fail  = 0;

    mc_control_fsm dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .opcode        (opcode),
        .mem_ready     (mem_ready),
        .pc_write      (pc_write),
        .pc_write_cond (pc_write_cond),
        .ir_write      (ir_write),
        .reg_write     (reg_write),
        .mem_read      (mem_read),
        .mem_write     (mem_write),
        .i_or_d        (i_or_d),
        .mem_to_reg    (mem_to_reg),
        .reg_dst       (reg_dst),
        .alu_src_a     (alu_src_a),
        .alu_src_b     (alu_src_b),
        .alu_op        (alu_op),
        .pc_source     (pc_source),
        .retire        (retire),
        .illegal_op    (illegal_op)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    ctl_t obs;
    assign obs = {pc_write, pc_write_cond, ir_write, reg_write, mem_read, mem_write,
                  i_or_d, mem_to_reg, reg_dst, alu_src_a, alu_src_b, alu_op,
                  pc_source, retire, illegal_op};

    function automatic ctl_t mk(input logic pcw, input logic pcwc, input logic irw,
                                input logic rw, input logic mr, input logic mw,
                                input logic iod, input logic m2r, input logic rd,
                                input logic asa, input logic [1:0] asb,
                                input logic [2:0] aop, input logic [1:0] pcs,
                                input logic ret, input logic ill);
        return {pcw, pcwc, irw, rw, mr, mw, iod, m2r, rd, asa, asb, aop, pcs, ret, ill};
    endfunction

    // Expected control words per state, written out from the state table
    function automatic ctl_t e_fetch(input logic rdy);
        return mk(rdy,0,rdy,0,1,0,0,0,0,0,2'b01,3'b000,2'b00,0,0);
    endfunction
    function automatic ctl_t e_decode();
        return mk(0,0,0,0,0,0,0,0,0,0,2'b11,3'b000,2'b00,0,0);
    endfunction
    function automatic ctl_t e_maddr();
        return mk(0,0,0,0,0,0,0,0,0,1,2'b10,3'b000,2'b00,0,0);
    endfunction
    function automatic ctl_t e_mread();
        return mk(0,0,0,0,1,0,1,0,0,0,2'b00,3'b000,2'b00,0,0);
    endfunction
    function automatic ctl_t e_mwb();
        return mk(0,0,0,1,0,0,0,1,0,0,2'b00,3'b000,2'b00,1,0);
    endfunction
    function automatic ctl_t e_mwrite(input logic rdy);
        return mk(0,0,0,0,0,1,1,0,0,0,2'b00,3'b000,2'b00,rdy,0);
    endfunction
    function automatic ctl_t e_rexec();
        return mk(0,0,0,0,0,0,0,0,0,1,2'b00,3'b010,2'b00,0,0);
    endfunction
    function automatic ctl_t e_rwb();
        return mk(0,0,0,1,0,0,0,0,1,0,2'b00,3'b000,2'b00,1,0);
    endfunction
    function automatic ctl_t e_iexec(input logic [2:0] aop);
        return mk(0,0,0,0,0,0,0,0,0,1,2'b10,aop,2'b00,0,0);
    endfunction
    function automatic ctl_t e_iwb();
        return mk(0,0,0,1,0,0,0,0,0,0,2'b00,3'b000,2'b00,1,0);
    endfunction
    function automatic ctl_t e_branch();
        return mk(0,1,0,0,0,0,0,0,0,1,2'b00,3'b001,2'b01,1,0);
    endfunction
    function automatic ctl_t e_jump();
        return mk(1,0,0,0,0,0,0,0,0,0,2'b00,3'b000,2'b10,1,0);
    endfunction
    function automatic ctl_t e_halt();
        return mk(0,0,0,0,0,0,0,0,0,0,2'b00,3'b000,2'b00,0,1);
    endfunction

    task automatic check(input string tag, input ctl_t got, input ctl_t exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b", tag, got, exp);
        end
    endtask

    // Advance one cycle, drive inputs at the falling edge, check just after
    task automatic step(input string tag, input logic rdy, input logic [5:0] op,
                        input ctl_t exp);
        @(negedge clk);
        mem_ready = rdy;
        opcode    = op;
        #1;
        check(tag, obs, exp);
    endtask

    task automatic reset_and_release(input string tag);
        @(negedge clk);
        rst_n = 1'b0;
        #1 check({tag, "_held"}, obs, '0);
        @(negedge clk);
        rst_n = 1'b1;
        #1 check({tag, "_reset_cyc"}, obs, '0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n     = 1'b0;
        opcode    = 6'b000000;
        mem_ready = 1'b1;
        #2 check("reset_held_t0", obs, '0);

        // R-type: RESET, FETCH, DECODE, R_EXEC, R_WB; retire only in cycle 5
        reset_and_release("rtype");
        step("rtype_fetch",  1, 6'b000000, e_fetch(1));
        step("rtype_decode", 1, 6'b000000, e_decode());
        step("rtype_exec",   1, 6'b111111, e_rexec());
        step("rtype_wb",     1, 6'b111111, e_rwb());

        // LW with one FETCH stall and three MEM_READ stalls; opcode scrambled
        // after DECODE must not matter
        step("lw_fetch_wait", 0, 6'b100011, e_fetch(0));
        step("lw_fetch",      1, 6'b100011, e_fetch(1));
        step("lw_decode",     1, 6'b100011, e_decode());
        step("lw_maddr",      0, 6'b000010, e_maddr());
        for (int i = 0; i < 3; i++)
            step($sformatf("lw_mread_wait%0d", i), 0, 6'b000010, e_mread());
        step("lw_mread_done", 1, 6'b000010, e_mread());
        step("lw_mwb",        0, 6'b000010, e_mwb());

        // I-type: ORI, ANDI, SLTI, ADDI
        begin
            logic [5:0] iops [4];
            logic [2:0] iaop [4];
            iops[0] = 6'b001101; iaop[0] = 3'b011;
            iops[1] = 6'b001100; iaop[1] = 3'b101;
            iops[2] = 6'b001010; iaop[2] = 3'b100;
            iops[3] = 6'b001000; iaop[3] = 3'b000;
            for (int k = 0; k < 4; k++) begin
                step($sformatf("itype%0d_fetch", k),  1, iops[k], e_fetch(1));
                step($sformatf("itype%0d_decode", k), 1, iops[k], e_decode());
                step($sformatf("itype%0d_exec", k),   0, 6'b000000, e_iexec(iaop[k]));
                step($sformatf("itype%0d_wb", k),     1, 6'b000000, e_iwb());
            end
        end

        // BEQ then J, three cycles each
        step("beq_fetch",  1, 6'b000100, e_fetch(1));
        step("beq_decode", 1, 6'b000100, e_decode());
        step("beq_branch", 0, 6'b000010, e_branch());
        step("j_fetch",    1, 6'b000010, e_fetch(1));
        step("j_decode",   1, 6'b000010, e_decode());
        step("j_jump",     0, 6'b000000, e_jump());

        // SW with one write stall; retire only in the ready cycle
        step("sw_fetch",      1, 6'b101011, e_fetch(1));
        step("sw_decode",     1, 6'b101011, e_decode());
        step("sw_maddr",      1, 6'b101011, e_maddr());
        step("sw_mwrite_wait", 0, 6'b101011, e_mwrite(0));
        step("sw_mwrite_done", 1, 6'b101011, e_mwrite(1));
        step("sw_next_fetch",  1, 6'b101011, e_fetch(1));

        // SW interrupted by reset in MEM_WRITE: mem_write drops without an edge
        step("swr_decode",      1, 6'b101011, e_decode());
        step("swr_maddr",       0, 6'b101011, e_maddr());
        step("swr_mwrite_wait", 0, 6'b101011, e_mwrite(0));
        #2 rst_n = 1'b0;
        #1 check("swr_async_drop", obs, '0);
        @(negedge clk);
        #1 check("swr_held_no_retire", obs, '0);
        rst_n = 1'b1;
        #1 check("swr_reset_cyc", obs, '0);
        step("swr_fetch_after", 1, 6'b000000, e_fetch(1));

        // Unsupported opcode: HALT for 20 cycles of toggling mem_ready
        step("ill_decode", 1, 6'b111111, e_decode());
        for (int i = 0; i < 20; i++)
            step($sformatf("halt_%0d", i), logic'(i[0]), 6'b000000, e_halt());
        reset_and_release("halt_exit");
        step("halt_exit_fetch", 1, 6'b000000, e_fetch(1));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
